// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with pending-write scoreboard.
package regfile_pkg;
  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 64;
  localparam int ZERO_REG = 0;

  typedef logic [$clog2(RF_DEPTH)-1:0] reg_addr_t;
  typedef logic [RF_WIDTH-1:0]         reg_word_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, issue-over-clear priority,
// registered pending count and combinational busy lookup for both read ports.
// REGFILE_BYPASS_EN: a same-cycle writeback hides busy on a matching read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DEPTH  = RF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] rd1,
  input  logic [ADDR_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pend_count
);

  logic [DEPTH-1:0] pending, set_v, clr_v;
  logic             inc, dec;
  logic             do_issue, do_wb;

  assign do_issue = issue_valid && (issue_reg != ADDR_W'(ZERO_REG));
  assign do_wb    = wb_en && (wb_reg != ADDR_W'(ZERO_REG));

  // One-hot set/clear masks; count deltas only on real 0->1 / 1->0 transitions.
  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (do_issue) set_v[issue_reg] = 1'b1;
    if (do_wb)    clr_v[wb_reg]    = 1'b1;
    inc = |(set_v & ~pending);
    dec = |(clr_v & pending & ~set_v);
  end

  // Pending bits and population count; issue overrides a same-register clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      pend_count <= '0;
    end else begin
      pending    <= (pending & ~clr_v) | set_v;
      pend_count <= pend_count + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
    end
  end

  // Busy lookup; pending[0] can never be set so address 0 reads idle.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    busy1 = pending[rd1] & ~(do_wb && rd1 == wb_reg && !(do_issue && issue_reg == wb_reg));
    busy2 = pending[rd2] & ~(do_wb && rd2 == wb_reg && !(do_issue && issue_reg == wb_reg));
`else
    busy1 = pending[rd1];
    busy2 = pending[rd2];
`endif
  end

endmodule

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with integrated pending-write scoreboard.
// Register 0 reads as zero and ignores writes.
// REGFILE_BYPASS_EN: write-through of WriteData to matching read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int WIDTH  = RF_WIDTH,
  parameter  int DEPTH  = RF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  output logic [WIDTH-1:0]  Data1,
  output logic [WIDTH-1:0]  Data2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] IssueReg,
  input  logic              IssueValid,
  output logic              Busy1,
  output logic              Busy2,
  output logic              Stall,
  output logic [ADDR_W:0]   PendCount
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;

  assign wr_en = RegWrite && (WriteReg != ADDR_W'(ZERO_REG));

  // Storage; entry 0 is never written so it stays zero after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[WriteReg] <= WriteData;
    end
  end

  // Combinational read muxes with hardwired zero and optional write-through.
  always_comb begin
    Data1 = (Read1 == ADDR_W'(ZERO_REG)) ? '0 : mem[Read1];
    Data2 = (Read2 == ADDR_W'(ZERO_REG)) ? '0 : mem[Read2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && Read1 == WriteReg) Data1 = WriteData;
    if (wr_en && Read2 == WriteReg) Data2 = WriteData;
`endif
  end

  regfile_scoreboard #(.DEPTH(DEPTH)) u_sb (
    .clock      (clock),
    .reset      (reset),
    .issue_reg  (IssueReg),
    .issue_valid(IssueValid),
    .wb_reg     (WriteReg),
    .wb_en      (RegWrite),
    .rd1        (Read1),
    .rd2        (Read2),
    .busy1      (Busy1),
    .busy2      (Busy2),
    .pend_count (PendCount)
  );

  assign Stall = Busy1 | Busy2;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized + directed bench for regfile_sb against an array/bit-vector model.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  Read1, Read2, WriteReg, IssueReg;
  logic [31:0] Data1, Data2, WriteData;
  logic        RegWrite, IssueValid, Busy1, Busy2, Stall;
  logic [6:0]  PendCount;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mreg [64];
  bit   [63:0] mpend;

  regfile_sb dut (
    .clock(clock), .reset(reset),
    .Read1(Read1), .Read2(Read2), .Data1(Data1), .Data2(Data2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .IssueReg(IssueReg), .IssueValid(IssueValid),
    .Busy1(Busy1), .Busy2(Busy2), .Stall(Stall), .PendCount(PendCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mreg[i] = '0;
    mpend = '0;
  endtask

  // One cycle: drive at negedge, check before the edge, update the model at the edge.
  task automatic step(input logic [5:0] r1, input logic [5:0] r2,
                      input logic rw, input logic [5:0] wr, input logic [31:0] wd,
                      input logic iv, input logic [5:0] ir);
    logic [31:0] ed1, ed2;
    logic        eb1, eb2;
    bit          wb, keep;
    Read1 = r1; Read2 = r2; RegWrite = rw; WriteReg = wr; WriteData = wd;
    IssueValid = iv; IssueReg = ir;
    #1;
    wb   = rw && wr != 0;
    keep = iv && ir == wr;
    ed1 = (r1 == 0) ? 32'h0 : (BYP && wb && r1 == wr) ? wd : mreg[r1];
    ed2 = (r2 == 0) ? 32'h0 : (BYP && wb && r2 == wr) ? wd : mreg[r2];
    eb1 = (BYP && wb && r1 == wr && !keep) ? 1'b0 : mpend[r1];
    eb2 = (BYP && wb && r2 == wr && !keep) ? 1'b0 : mpend[r2];
    chk("data1", Data1, ed1);
    chk("data2", Data2, ed2);
    chk("busy1", Busy1, eb1);
    chk("busy2", Busy2, eb2);
    chk("stall", Stall, eb1 | eb2);
    chk("pendcount", PendCount, $countones(mpend));
    @(posedge clock);
    if (wb) begin
      mreg[wr]  = wd;
      mpend[wr] = 1'b0;
    end
    if (iv && ir != 0) mpend[ir] = 1'b1;
    @(negedge clock);
  endtask

  // Reset asserted between edges; outputs must clear before any edge.
  task automatic async_reset(input logic [5:0] r1);
    Read1 = r1; Read2 = r1; RegWrite = 0; IssueValid = 0;
    #2 reset = 1'b1;
    #1;
    chk("rst_data1", Data1, 32'h0);
    chk("rst_busy1", Busy1, 1'b0);
    chk("rst_pend", PendCount, 7'd0);
    model_clear();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    Read1 = 0; Read2 = 0; WriteReg = 0; WriteData = 0; RegWrite = 0;
    IssueReg = 0; IssueValid = 0;
    model_clear();
    #1;
    chk("init_data1", Data1, 32'h0);
    chk("init_stall", Stall, 1'b0);
    chk("init_pend", PendCount, 7'd0);
    @(negedge clock);
    reset = 1'b0;

    // Reset discards written data
    step(0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    step(5, 5, 0, 0, 0, 0, 0);
    chk("rd5_before_rst", Data1, 32'hDEADBEEF);
    async_reset(5);

    // Basic write/read and register 0
    step(0, 0, 1, 7, 32'h12345678, 0, 0);
    step(7, 7, 0, 0, 0, 0, 0);
    chk("rd7_p1", Data1, 32'h12345678);
    chk("rd7_p2", Data2, 32'h12345678);
    step(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rd0", Data1, 32'h0);

    // Issue and writeback reg 3
    step(0, 0, 0, 0, 0, 1, 3);
    step(3, 0, 0, 0, 0, 0, 0);
    chk("busy3", Busy1, 1'b1);
    chk("pend1", PendCount, 7'd1);
    step(3, 0, 1, 3, 32'hA5, 0, 0);
    step(3, 0, 0, 0, 0, 0, 0);
    chk("wb3_data", Data1, 32'hA5);
    chk("wb3_busy", Busy1, 1'b0);

    // Same-cycle issue/writeback on reg 4; issue 9 while retiring 2
    step(0, 0, 0, 0, 0, 1, 4);
    step(4, 0, 1, 4, 32'h44, 1, 4);
    step(4, 0, 0, 0, 0, 1, 2);
    chk("busy4_kept", Busy1, 1'b1);
    chk("pend_4_2", PendCount, 7'd2);
    step(9, 2, 1, 2, 32'h22, 1, 9);
    step(9, 2, 0, 0, 0, 0, 0);
    chk("busy9", Busy1, 1'b1);
    chk("busy2_clr", Busy2, 1'b0);
    chk("pend_net0", PendCount, 7'd2);

    // Saturation
    for (int i = 1; i < 64; i++) step(6'(i), 0, 0, 0, 0, 1, 6'(i));
    step(10, 0, 0, 0, 0, 1, 10);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("sat63", PendCount, 7'd63);

    // Bypass window: reg 6 pending, writeback 0x55 while reading it
    async_reset(6);
    step(0, 0, 1, 6, 32'h11, 1, 6);
    step(6, 6, 1, 6, 32'h55, 0, 0);
    step(6, 0, 0, 0, 0, 0, 0);
    chk("rd6_after", Data1, 32'h55);

    // Random traffic on a small address window to force collisions
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) async_reset(6'($urandom_range(0, 63)));
      else step(6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), $urandom,
                1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)));
    end
    // Wide random addresses
    for (int n = 0; n < 300; n++)
      step(6'($urandom), 6'($urandom), 1'($urandom), 6'($urandom), $urandom,
           1'($urandom), 6'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
